// File: rtl/hwpf_req_responder.sv
// Cache-side responder for the HW-prefetcher request port: queues requests, retires each after a fixed
// head latency and emits tagged response and snoop pulses. Optional counters: HWPF_REQ_RESPONDER_STATS_EN.
module hwpf_req_responder #(
   parameter int unsigned TAG_W        = 36,
   parameter int unsigned OFFSET_W     = 12,
   parameter int unsigned CLOFFSET_W   = 6,
   parameter int unsigned OP_W         = 4,
   parameter logic [OP_W-1:0] PF_OP_CODE = 4'h8,
   parameter int unsigned TID_W        = 4,
   parameter int unsigned SID_W        = 3,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RSP_LATENCY  = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [OFFSET_W-1:0] req_addr_offset_i,
   input  logic [TAG_W-1:0]    req_addr_tag_i,
   input  logic [OP_W-1:0]     req_op_i,
   input  logic [TID_W-1:0]    req_tid_i,
   input  logic [SID_W-1:0]    req_sid_i,
   input  logic                req_need_rsp_i,
   input  logic                req_phys_indexed_i,
   output logic                rsp_valid_o,
   output logic [TID_W-1:0]    rsp_tid_o,
   output logic [SID_W-1:0]    rsp_sid_o,
   output logic                rsp_error_o,
   output logic                snoop_valid_o,
   output logic                snoop_abort_o,
   output logic                snoop_phys_indexed_o,
   output logic [OFFSET_W-1:0] snoop_addr_offset_o,
   output logic [TAG_W-1:0]    snoop_addr_tag_o,
   output logic                busy_o
`ifdef HWPF_REQ_RESPONDER_STATS_EN
   ,
   output logic [31:0]         stat_accepted_o,
   output logic [31:0]         stat_errors_o
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
   localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(RSP_LATENCY - 1);
   localparam logic [OFFSET_W-1:0] LINE_MASK  = {{(OFFSET_W - CLOFFSET_W){1'b1}}, {CLOFFSET_W{1'b0}}};

   typedef struct packed {
      logic [OFFSET_W-1:0] offset;
      logic [TAG_W-1:0]    tag;
      logic [TID_W-1:0]    tid;
      logic [SID_W-1:0]    sid;
      logic                need_rsp;
      logic                err;
   } entry_t;

   entry_t           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [CNT_W-1:0] head_cnt_reg;

   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   entry_t push_entry;
   entry_t head;

   assign full  = (count_reg == FULL_COUNT);
   assign empty = (count_reg == '0);
   assign push  = req_valid_i & ~full;
   assign pop   = ~empty & (head_cnt_reg == LAST_CNT);
   assign head  = fifo_mem[rd_ptr_reg];

   assign req_ready_o          = ~full;
   assign busy_o               = ~empty;
   assign snoop_abort_o        = 1'b0;
   assign snoop_phys_indexed_o = 1'b1;

   always_comb begin
      push_entry          = '0;
      push_entry.offset   = req_addr_offset_i;
      push_entry.tag      = req_addr_tag_i;
      push_entry.tid      = req_tid_i;
      push_entry.sid      = req_sid_i;
      push_entry.need_rsp = req_need_rsp_i;
      push_entry.err      = (req_op_i != PF_OP_CODE) | ~req_phys_indexed_i;
   end

   // Payload storage needs no reset: occupancy is tracked entirely by count_reg.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         head_cnt_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
            default: count_reg <= count_reg;
         endcase
         // A freshly exposed head always starts its latency window from zero.
         if (pop || empty) begin
            head_cnt_reg <= '0;
         end else begin
            head_cnt_reg <= head_cnt_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o         <= 1'b0;
         snoop_valid_o       <= 1'b0;
         rsp_tid_o           <= '0;
         rsp_sid_o           <= '0;
         rsp_error_o         <= 1'b0;
         snoop_addr_offset_o <= '0;
         snoop_addr_tag_o    <= '0;
      end else begin
         rsp_valid_o   <= pop & (head.need_rsp | head.err);
         snoop_valid_o <= pop & ~head.err;
         if (pop) begin
            rsp_tid_o           <= head.tid;
            rsp_sid_o           <= head.sid;
            rsp_error_o         <= head.err;
            snoop_addr_offset_o <= head.offset & LINE_MASK;
            snoop_addr_tag_o    <= head.tag;
         end
      end
   end

`ifdef HWPF_REQ_RESPONDER_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_accepted_o <= '0;
         stat_errors_o   <= '0;
      end else begin
         if (push && (stat_accepted_o != 32'hFFFF_FFFF)) begin
            stat_accepted_o <= stat_accepted_o + 32'd1;
         end
         if (pop && head.err && (stat_errors_o != 32'hFFFF_FFFF)) begin
            stat_errors_o <= stat_errors_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/hwpf_req_responder.md
Name: hwpf_req_responder

Overview:
- Request-side endpoint of the HW-prefetcher request port.
- Accepts physically indexed prefetch requests over valid/ready and buffers them in a FIFO.
- Retires each request after a fixed service latency. On retire it returns a tid/sid-tagged response and drives a snoop event (line offset + tag) back toward the prefetcher snoop ports.
- Used as the cache-side model/stub for prefetcher integration and as the issue-side snoop source.

Parameters:
- TAG_W, 36, address tag width
- OFFSET_W, 12, request address offset width
- CLOFFSET_W, 6, cache-line byte-offset bits inside the offset
- OP_W, 4, request opcode width
- PF_OP_CODE, 4'h8, the only opcode serviced without error
- TID_W, 4, transaction id width
- SID_W, 3, source id width
- FIFO_DEPTH, 4, pending request slots (power of two, >=2)
- RSP_LATENCY, 3, cycles a request spends at FIFO head before retiring (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_offset_i  in  OFFSET_W  request address offset
- req_addr_tag_i  in  TAG_W  request tag, sampled with the request
- req_op_i  in  OP_W  opcode
- req_tid_i  in  TID_W  transaction id
- req_sid_i  in  SID_W  source id
- req_need_rsp_i  in  1  response requested
- req_phys_indexed_i  in  1  physically indexed flag
- rsp_valid_o  out  1  response pulse, no backpressure
- rsp_tid_o  out  TID_W  echoed tid
- rsp_sid_o  out  SID_W  echoed sid
- rsp_error_o  out  1  unsupported op or non-physically-indexed request
- snoop_valid_o  out  1  snoop pulse
- snoop_abort_o  out  1  tied 0
- snoop_phys_indexed_o  out  1  tied 1
- snoop_addr_offset_o  out  OFFSET_W  retired offset, line bits zeroed
- snoop_addr_tag_o  out  TAG_W  retired tag
- busy_o  out  1  FIFO non-empty

Behaviour:
- Reset: FIFO empty, head counter 0, every registered output 0; req_ready_o=1 out of reset.
- Handshake: accept when req_valid_i & req_ready_o. req_ready_o = !full, combinational from the FIFO count only; it never depends on req_valid_i.
  - No push when full, even if a pop occurs in the same cycle.
- Capture on accept: offset, tag, tid, sid, need_rsp, and err = (req_op_i != PF_OP_CODE) | !req_phys_indexed_i. The entry is visible in the FIFO the next cycle.
- Head counter:
  - Cleared on pop and while the FIFO is empty.
  - Increments each cycle the head is valid.
  - Head pops at the end of the cycle where counter == RSP_LATENCY-1.
- Timing: isolated request accepted in cycle t -> outputs high in cycle t+RSP_LATENCY+1. Back-to-back retires are spaced RSP_LATENCY cycles apart.
- Retire outputs: registered one-cycle pulses in the cycle after the pop.
  - rsp_valid_o = need_rsp | err.
  - snoop_valid_o = !err.
  - snoop_addr_offset_o = offset with the low CLOFFSET_W bits cleared.
  - rsp_tid_o, rsp_sid_o and rsp_error_o hold the retired entry's values. Between pulses they hold their last value.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- busy_o = count != 0.
- Reset mid-operation: FIFO flushed; in-flight requests produce no response or snoop; pulses due in the cycle reset asserts are dropped.
- Tid values are not checked for uniqueness. Responses are strictly in request order.

Optional Feature:
- Macro HWPF_REQ_RESPONDER_STATS_EN.
- When defined, two extra outputs are added:
  - stat_accepted_o [31:0]: counts handshakes.
  - stat_errors_o [31:0]: counts retired entries with err=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single prefetch: RSP_LATENCY=3, op=PF_OP_CODE, tid=5, sid=2, need_rsp=1, offset=12'h7C4, tag=36'h123, accepted in cycle 0 -> in cycle 4: rsp_valid_o=1, tid=5, sid=2, error=0, snoop_valid_o=1, offset=12'h7C0, tag=36'h123. All pulses low in cycles 3 and 5.
- Back-to-back: four requests tid 0..3 in cycles 0-3 -> responses in cycles 4, 7, 10, 13 in tid order. req_ready_o stays 1 throughout (FIFO never full).
- Full FIFO: FIFO_DEPTH=4, RSP_LATENCY=8, six requests held valid from cycle 0:
  - req_ready_o=0 from cycle 4.
  - 5th request accepted in cycle 9, 6th in cycle 17, each in the cycle after a pop frees a slot.
  - No request is lost or duplicated.
- Error path: op != PF_OP_CODE with need_rsp=0 -> rsp_valid_o=1 and rsp_error_o=1 at t+RSP_LATENCY+1; snoop_valid_o stays 0. Repeat with phys_indexed=0 -> same response.
- No-response prefetch: need_rsp=0, valid op -> snoop_valid_o pulse at t+RSP_LATENCY+1, rsp_valid_o stays 0.
- Reset mid-flight: two requests accepted, rst_ni low in cycle 2 -> busy_o=0 and req_ready_o=1 after reset, and no rsp/snoop pulses occur. With HWPF_REQ_RESPONDER_STATS_EN, counters read 0.
